corevx_loadunit: RTL and testbench

- Sequential, parametrised load unit sitting between the execute stage and the data-memory port.
- Accepts one load request, issues one aligned bus beat (or two when a split is enabled), then extracts and sign/zero-extends the addressed field.
- Returns the result with error flags over a valid/ready handshake.
- Generalises the combinational load generator to XLEN 32/64, adds LWU/LD, memory handshakes, fault propagation and optional misaligned splitting.

---
 rtl/corevx_loadunit_pkg.sv | 47 ++++
 rtl/corevx_loadunit_extract.sv | 32 +++
 rtl/corevx_loadunit.sv | 234 +++++++++++++++++++++++
 tb/tb_corevx_loadunit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corevx_loadunit_pkg.sv
// Shared definitions for the corevx load unit: load funct3 codes, FSM states,
// response flags and size/legality decode helpers.
package corevx_loadunit_pkg;

  localparam logic [2:0] LOAD_BYTE           = 3'b000;
  localparam logic [2:0] LOAD_HALF           = 3'b001;
  localparam logic [2:0] LOAD_WORD           = 3'b010;
  localparam logic [2:0] LOAD_DOUBLE         = 3'b011;
  localparam logic [2:0] LOAD_BYTE_UNSIGNED  = 3'b100;
  localparam logic [2:0] LOAD_HALF_UNSIGNED  = 3'b101;
  localparam logic [2:0] LOAD_WORD_UNSIGNED  = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_RESP
  } load_state_e;

  typedef struct packed {
    logic misaligned;
    logic unknown_type;
    logic access_fault;
  } load_flags_t;

  // Access size in bytes; 0 for an encoding with no defined size.
  function automatic logic [3:0] load_size(input logic [2:0] ltype);
    case (ltype)
      LOAD_BYTE, LOAD_BYTE_UNSIGNED: return 4'd1;
      LOAD_HALF, LOAD_HALF_UNSIGNED: return 4'd2;
      LOAD_WORD, LOAD_WORD_UNSIGNED: return 4'd4;
      LOAD_DOUBLE:                   return 4'd8;
      default:                       return 4'd0;
    endcase
  endfunction

  function automatic logic load_type_legal(input logic [2:0] ltype, input logic xlen64);
    case (ltype)
      LOAD_DOUBLE, LOAD_WORD_UNSIGNED: return xlen64;
      3'b111:                          return 1'b0;
      default:                         return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/corevx_loadunit_extract.sv
// Combinational field extraction: shifts {beat1, beat0} right by the byte
// offset and sign/zero-extends the addressed field to XLEN.
module corevx_loadunit_extract
  import corevx_loadunit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0]          beats_i,
  input  logic [$clog2(XLEN/8)-1:0]  offset_i,
  input  logic [2:0]                 ltype_i,
  output logic [XLEN-1:0]            data_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = XLEN'(beats_i >> {offset_i, 3'b000});

  always_comb begin
    data_o = '0;
    case (ltype_i)
      LOAD_BYTE:          data_o = XLEN'($signed(shifted[7:0]));
      LOAD_HALF:          data_o = XLEN'($signed(shifted[15:0]));
      LOAD_WORD:          data_o = XLEN'($signed(shifted[31:0]));
      LOAD_DOUBLE:        data_o = shifted;
      LOAD_BYTE_UNSIGNED: data_o = XLEN'(shifted[7:0]);
      LOAD_HALF_UNSIGNED: data_o = XLEN'(shifted[15:0]);
      LOAD_WORD_UNSIGNED: data_o = XLEN'(shifted[31:0]);
      default:            data_o = '0;
    endcase
  end

endmodule

// File: rtl/corevx_loadunit.sv
// Sequential load unit: one request -> one (or two) aligned bus beats ->
// extended result with error flags. Two-beat misaligned servicing is enabled
// by defining COREVX_LOADUNIT_MISALIGNED_SPLIT_EN.
module corevx_loadunit
  import corevx_loadunit_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [2:0]        ReqType,
  output logic              MemReqValid,
  input  logic              MemReqReady,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemRespValid,
  input  logic [XLEN-1:0]   MemRespData,
  input  logic              MemRespError,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [XLEN-1:0]   RspData,
  output logic              RspMisaligned,
  output logic              RspUnknownType,
  output logic              RspAccessFault
);

  localparam int unsigned BEAT_BYTES = XLEN / 8;
  localparam int unsigned OFF_W      = $clog2(BEAT_BYTES);

  load_state_e       state_q, state_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [2:0]        type_q, type_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  load_flags_t       flags_q, flags_d;

  logic [3:0]        size_c;
  logic              legal_c;
  logic [ADDR_W-1:0] aligned_c;
  logic [XLEN-1:0]   beat0_sel_c, beat1_sel_c;
  logic [XLEN-1:0]   ext_data_c;

  assign size_c    = load_size(ReqType);
  assign legal_c   = load_type_legal(ReqType, XLEN == 64);
  assign aligned_c = {ReqAddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

`ifdef COREVX_LOADUNIT_MISALIGNED_SPLIT_EN
  logic [XLEN-1:0] beat0_q, beat0_d;
  logic            cross_q, cross_d;
  logic            cross_c;

  // The load needs a second beat when its last byte falls past this beat.
  assign cross_c     = (5'(ReqAddr[OFF_W-1:0]) + 5'(size_c)) > 5'(BEAT_BYTES);
  assign beat0_sel_c = (state_q == ST_WAIT1) ? beat0_q : MemRespData;
  assign beat1_sel_c = (state_q == ST_WAIT1) ? MemRespData : '0;
`else
  logic misal_c;

  assign misal_c     = (ReqAddr[2:0] & 3'(size_c - 4'd1)) != 3'd0;
  assign beat0_sel_c = MemRespData;
  assign beat1_sel_c = '0;
`endif

  corevx_loadunit_extract #(
    .XLEN (XLEN)
  ) u_extract (
    .beats_i  ({beat1_sel_c, beat0_sel_c}),
    .offset_i (offset_q),
    .ltype_i  (type_q),
    .data_o   (ext_data_c)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      offset_q        <= '0;
      type_q          <= '0;
      req_ready_q     <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      flags_q         <= '0;
`ifdef COREVX_LOADUNIT_MISALIGNED_SPLIT_EN
      beat0_q         <= '0;
      cross_q         <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      offset_q        <= offset_d;
      type_q          <= type_d;
      req_ready_q     <= req_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      flags_q         <= flags_d;
`ifdef COREVX_LOADUNIT_MISALIGNED_SPLIT_EN
      beat0_q         <= beat0_d;
      cross_q         <= cross_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d         = state_q;
    offset_d        = offset_q;
    type_d          = type_q;
    req_ready_d     = req_ready_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_addr_d      = mem_addr_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_data_d      = rsp_data_q;
    flags_d         = flags_q;
`ifdef COREVX_LOADUNIT_MISALIGNED_SPLIT_EN
    beat0_d         = beat0_q;
    cross_d         = cross_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (ReqValid) begin
          offset_d    = ReqAddr[OFF_W-1:0];
          type_d      = ReqType;
          req_ready_d = 1'b0;
          rsp_data_d  = '0;
          flags_d     = '0;
          if (!legal_c) begin
            flags_d.unknown_type = 1'b1;
            rsp_valid_d          = 1'b1;
            state_d              = ST_RESP;
          end
`ifndef COREVX_LOADUNIT_MISALIGNED_SPLIT_EN
          else if (misal_c) begin
            flags_d.misaligned = 1'b1;
            rsp_valid_d        = 1'b1;
            state_d            = ST_RESP;
          end
`endif
          else begin
            mem_req_valid_d = 1'b1;
            mem_addr_d      = aligned_c;
            state_d         = ST_REQ0;
`ifdef COREVX_LOADUNIT_MISALIGNED_SPLIT_EN
            cross_d         = cross_c;
`endif
          end
        end
      end

      ST_REQ0: begin
        if (MemReqReady) begin
          mem_req_valid_d = 1'b0;
          state_d         = ST_WAIT0;
        end
      end

      ST_WAIT0: begin
        if (MemRespValid) begin
          if (MemRespError) begin
            flags_d.access_fault = 1'b1;
            rsp_data_d           = '0;
            rsp_valid_d          = 1'b1;
            state_d              = ST_RESP;
          end
`ifdef COREVX_LOADUNIT_MISALIGNED_SPLIT_EN
          else if (cross_q) begin
            beat0_d         = MemRespData;
            mem_req_valid_d = 1'b1;
            mem_addr_d      = mem_addr_q + ADDR_W'(BEAT_BYTES);
            state_d         = ST_REQ1;
          end
`endif
          else begin
            rsp_data_d  = ext_data_c;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end
        end
      end

`ifdef COREVX_LOADUNIT_MISALIGNED_SPLIT_EN
      ST_REQ1: begin
        if (MemReqReady) begin
          mem_req_valid_d = 1'b0;
          state_d         = ST_WAIT1;
        end
      end

      ST_WAIT1: begin
        if (MemRespValid) begin
          flags_d.access_fault = flags_q.access_fault | MemRespError;
          rsp_data_d           = MemRespError ? '0 : ext_data_c;
          rsp_valid_d          = 1'b1;
          state_d              = ST_RESP;
        end
      end
`endif

      ST_RESP: begin
        if (RspReady) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d         = ST_IDLE;
        req_ready_d     = 1'b1;
        mem_req_valid_d = 1'b0;
        rsp_valid_d     = 1'b0;
      end
    endcase
  end

  assign ReqReady       = req_ready_q;
  assign MemReqValid    = mem_req_valid_q;
  assign MemAddr        = mem_addr_q;
  assign RspValid       = rsp_valid_q;
  assign RspData        = rsp_data_q;
  assign RspMisaligned  = flags_q.misaligned;
  assign RspUnknownType = flags_q.unknown_type;
  assign RspAccessFault = flags_q.access_fault;

endmodule

// File: tb/tb_corevx_loadunit.sv
// Directed bench for corevx_loadunit: an XLEN=32 and an XLEN=64 instance,
// each behind a one-cycle-latency memory responder.
module tb_corevx_loadunit;

  logic clk, rst_n;

  logic        a_req_valid, a_req_ready;
  logic [31:0] a_req_addr;
  logic [2:0]  a_req_type;
  logic        a_mem_req_valid, a_mem_req_ready;
  logic [31:0] a_mem_addr;
  logic        a_mem_resp_valid, a_mem_resp_error;
  logic [31:0] a_mem_resp_data;
  logic        a_rsp_valid, a_rsp_ready;
  logic [31:0] a_rsp_data;
  logic        a_mis, a_unk, a_flt;

  logic        b_req_valid, b_req_ready;
  logic [31:0] b_req_addr;
  logic [2:0]  b_req_type;
  logic        b_mem_req_valid, b_mem_req_ready;
  logic [31:0] b_mem_addr;
  logic        b_mem_resp_valid, b_mem_resp_error;
  logic [63:0] b_mem_resp_data;
  logic        b_rsp_valid, b_rsp_ready;
  logic [63:0] b_rsp_data;
  logic        b_mis, b_unk, b_flt;

  int n_checks = 0;
  int n_errors = 0;

  // Responder bookkeeping
  logic        a_pend, b_pend, a_stall, inject_err;
  logic [31:0] a_pend_addr, b_pend_addr;
  int          a_beats, b_beats;
  logic        a_seen, b_seen;
  logic [31:0] a_addr0, a_addr1, b_addr0, b_addr1;

  // Results of the last run_req
  logic [63:0] r_data;
  logic [2:0]  r_flags;
  int          r_beats, r_lat;
  logic        r_seen, r_ok;

  corevx_loadunit #(.XLEN(32), .ADDR_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .ReqValid(a_req_valid), .ReqReady(a_req_ready), .ReqAddr(a_req_addr), .ReqType(a_req_type),
    .MemReqValid(a_mem_req_valid), .MemReqReady(a_mem_req_ready), .MemAddr(a_mem_addr),
    .MemRespValid(a_mem_resp_valid), .MemRespData(a_mem_resp_data), .MemRespError(a_mem_resp_error),
    .RspValid(a_rsp_valid), .RspReady(a_rsp_ready), .RspData(a_rsp_data),
    .RspMisaligned(a_mis), .RspUnknownType(a_unk), .RspAccessFault(a_flt)
  );

  corevx_loadunit #(.XLEN(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .ReqValid(b_req_valid), .ReqReady(b_req_ready), .ReqAddr(b_req_addr), .ReqType(b_req_type),
    .MemReqValid(b_mem_req_valid), .MemReqReady(b_mem_req_ready), .MemAddr(b_mem_addr),
    .MemRespValid(b_mem_resp_valid), .MemRespData(b_mem_resp_data), .MemRespError(b_mem_resp_error),
    .RspValid(b_rsp_valid), .RspReady(b_rsp_ready), .RspData(b_rsp_data),
    .RspMisaligned(b_mis), .RspUnknownType(b_unk), .RspAccessFault(b_flt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem32(input logic [31:0] addr);
    case (addr)
      32'h100: return 32'h8899AABB;
      32'h104: return 32'h11223344;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  function automatic logic [63:0] mem64(input logic [31:0] addr);
    case (addr)
      32'h200: return 64'hA5A5A5A5_F0000000;
      32'h208: return 64'h01234567_89ABCDEF;
      default: return 64'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // 32-bit responder: answers each accepted read one cycle later unless stalled
  initial begin
    a_mem_resp_valid = 1'b0; a_mem_resp_data = '0; a_mem_resp_error = 1'b0;
    a_pend = 1'b0; a_pend_addr = '0;
    forever begin
      @(negedge clk);
      a_mem_resp_valid = a_pend && !a_stall;
      a_mem_resp_data  = a_mem_resp_valid ? mem32(a_pend_addr) : 32'h0;
      a_mem_resp_error = a_mem_resp_valid && inject_err;
      if (a_mem_resp_valid) begin
        a_pend = 1'b0;
        inject_err = 1'b0;
      end
      if (a_mem_req_valid) a_seen = 1'b1;
      if (a_mem_req_valid && a_mem_req_ready) begin
        if (a_beats == 0) a_addr0 = a_mem_addr; else a_addr1 = a_mem_addr;
        a_beats++;
        a_pend = 1'b1;
        a_pend_addr = a_mem_addr;
      end
    end
  end

  // 64-bit responder
  initial begin
    b_mem_resp_valid = 1'b0; b_mem_resp_data = '0; b_mem_resp_error = 1'b0;
    b_pend = 1'b0; b_pend_addr = '0;
    forever begin
      @(negedge clk);
      b_mem_resp_valid = b_pend;
      b_mem_resp_data  = b_pend ? mem64(b_pend_addr) : 64'h0;
      b_pend = 1'b0;
      if (b_mem_req_valid) b_seen = 1'b1;
      if (b_mem_req_valid && b_mem_req_ready) begin
        if (b_beats == 0) b_addr0 = b_mem_addr; else b_addr1 = b_mem_addr;
        b_beats++;
        b_pend = 1'b1;
        b_pend_addr = b_mem_addr;
      end
    end
  end

  // Present one request and wait (bounded) for RspValid; latency counts cycles
  // from the cycle the request is presented.
  task automatic run_req(input bit w64, input logic [31:0] addr, input logic [2:0] typ);
    @(negedge clk);
    a_beats = 0; b_beats = 0; a_seen = 1'b0; b_seen = 1'b0;
    if (w64) begin b_req_valid = 1'b1; b_req_addr = addr; b_req_type = typ; end
    else     begin a_req_valid = 1'b1; a_req_addr = addr; a_req_type = typ; end
    r_ok = 1'b0; r_lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      a_req_valid = 1'b0; b_req_valid = 1'b0;
      if (w64 ? b_rsp_valid : a_rsp_valid) begin
        r_ok = 1'b1; r_lat = i;
        break;
      end
    end
    check("rsp_arrived", 64'(r_ok), 64'd1);
    r_data  = w64 ? b_rsp_data : 64'(a_rsp_data);
    r_flags = w64 ? {b_mis, b_unk, b_flt} : {a_mis, a_unk, a_flt};
    r_beats = w64 ? b_beats : a_beats;
    r_seen  = w64 ? b_seen : a_seen;
  endtask

  task automatic ack(input bit w64);
    if (w64) b_rsp_ready = 1'b1; else a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
  endtask

  initial begin : main
    logic stable;
    rst_n = 1'b0; a_stall = 1'b0; inject_err = 1'b0;
    a_req_valid = 1'b0; a_req_addr = '0; a_req_type = '0; a_mem_req_ready = 1'b1; a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_addr = '0; b_req_type = '0; b_mem_req_ready = 1'b1; b_rsp_ready = 1'b0;
    a_beats = 0; b_beats = 0; a_seen = 1'b0; b_seen = 1'b0;
    a_addr0 = '0; a_addr1 = '0; b_addr0 = '0; b_addr1 = '0;
    repeat (2) @(negedge clk);

    check("rst_req_ready", 64'(a_req_ready), 64'd1);
    check("rst_mem_valid", 64'(a_mem_req_valid), 64'd0);
    check("rst_rsp_valid", 64'({a_rsp_valid, b_rsp_valid}), 64'd0);
    check("rst_rsp_data", 64'(a_rsp_data), 64'd0);
    check("rst_flags", 64'({a_mis, a_unk, a_flt}), 64'd0);
    rst_n = 1'b1;

    run_req(0, 32'h101, 3'b000);
    check("lb_data", r_data, 64'hFFFFFFAA);
    check("lb_beats", 64'(r_beats), 64'd1);
    check("lb_flags", 64'(r_flags), 64'd0);
    ack(0);

    run_req(0, 32'h102, 3'b101);
    check("lhu_data", r_data, 64'h00008899);
    check("lhu_beats", 64'(r_beats), 64'd1);
    check("lhu_flags", 64'(r_flags), 64'd0);
    ack(0);

    run_req(0, 32'h100, 3'b010);
    check("lw_latency", 64'(r_lat), 64'd3);
    check("lw_data", r_data, 64'h8899AABB);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'h8899AABB || a_req_ready !== 1'b0) stable = 1'b0;
    end
    check("lw_hold_stable", 64'(stable), 64'd1);
    ack(0);

`ifdef COREVX_LOADUNIT_MISALIGNED_SPLIT_EN
    run_req(0, 32'h102, 3'b010);
    check("split_lw_data", r_data, 64'h33448899);
    check("split_lw_beats", 64'(r_beats), 64'd2);
    check("split_lw_addr0", 64'(a_addr0), 64'h100);
    check("split_lw_addr1", 64'(a_addr1), 64'h104);
    check("split_lw_flags", 64'(r_flags), 64'd0);
    ack(0);

    run_req(0, 32'h101, 3'b001);
    check("lh_1beat_data", r_data, 64'hFFFF99AA);
    check("lh_1beat_beats", 64'(r_beats), 64'd1);
    ack(0);

    inject_err = 1'b1;
    run_req(0, 32'h102, 3'b010);
    check("fault_flags", 64'(r_flags), 64'b001);
    check("fault_data", r_data, 64'd0);
    check("fault_beats", 64'(r_beats), 64'd1);
    ack(0);

    run_req(1, 32'h204, 3'b011);
    check("x64_split_ld", r_data, 64'h89ABCDEF_A5A5A5A5);
    check("x64_split_addr1", 64'(b_addr1), 64'h208);
    ack(1);
`else
    run_req(0, 32'h102, 3'b010);
    check("mis_lw_flags", 64'(r_flags), 64'b100);
    check("mis_lw_data", r_data, 64'd0);
    check("mis_lw_no_bus", 64'(r_seen), 64'd0);
    ack(0);

    run_req(0, 32'h101, 3'b001);
    check("mis_lh_flags", 64'(r_flags), 64'b100);
    ack(0);

    inject_err = 1'b1;
    run_req(0, 32'h100, 3'b010);
    check("fault_flags", 64'(r_flags), 64'b001);
    check("fault_data", r_data, 64'd0);
    check("fault_beats", 64'(r_beats), 64'd1);
    ack(0);

    run_req(1, 32'h204, 3'b011);
    check("x64_mis_ld", 64'(r_flags), 64'b100);
    ack(1);
`endif

    run_req(0, 32'h100, 3'b111);
    check("unk111_flags", 64'(r_flags), 64'b010);
    check("unk111_data", r_data, 64'd0);
    ack(0);

    run_req(0, 32'h100, 3'b011);
    check("x32_ld_flags", 64'(r_flags), 64'b010);
    check("x32_ld_no_bus", 64'(r_seen), 64'd0);
    ack(0);

    run_req(1, 32'h200, 3'b110);
    check("x64_lwu", r_data, 64'h00000000_F0000000);
    check("x64_lwu_flags", 64'(r_flags), 64'd0);
    ack(1);

    run_req(1, 32'h204, 3'b010);
    check("x64_lw_sext", r_data, 64'hFFFFFFFF_A5A5A5A5);
    ack(1);

    run_req(1, 32'h200, 3'b011);
    check("x64_ld", r_data, 64'hA5A5A5A5_F0000000);
    ack(1);

    run_req(1, 32'h203, 3'b000);
    check("x64_lb", r_data, 64'hFFFFFFFF_FFFFFFF0);
    ack(1);

    run_req(1, 32'h200, 3'b111);
    check("x64_unk", 64'(r_flags), 64'b010);
    ack(1);

    // Reset while the unit waits for a stalled response
    a_stall = 1'b1;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_addr = 32'h100; a_req_type = 3'b000;
    @(negedge clk);
    a_req_valid = 1'b0;
    check("mid_req0_valid", 64'(a_mem_req_valid), 64'd1);
    @(negedge clk);
    check("mid_wait0_valid", 64'(a_mem_req_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    a_pend = 1'b0;
    check("mid_rst_req_ready", 64'(a_req_ready), 64'd1);
    check("mid_rst_mem_valid", 64'(a_mem_req_valid), 64'd0);
    check("mid_rst_rsp_valid", 64'(a_rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_stall = 1'b0;

    run_req(0, 32'h100, 3'b000);
    check("post_rst_lb", r_data, 64'hFFFFFFBB);
    check("post_rst_flags", 64'(r_flags), 64'd0);
    ack(0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
